// File: rtl/abl_seq.sv
// Low-address (ABL) cycle sequencer: walks one addressing-mode sequence per request,
// driving ABL stage selects, PCL/AHL loads and ABH page fix-up strobes.
module abl_seq #(
    parameter bit FIX_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       taken,
    input  logic       force_fix,
    input  logic       rdy,
    input  logic       co,
    input  logic       db7,
    output logic [2:0] op,
    output logic       ci,
    output logic       ld_ahl,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       abh_zp,
    output logic       abh_stk,
    output logic       abh_inc,
    output logic       abh_dec,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_OPR   = 4'd1;
    localparam logic [3:0] S_OPR2  = 4'd2;
    localparam logic [3:0] S_ZP    = 4'd3;
    localparam logic [3:0] S_AX    = 4'd4;
    localparam logic [3:0] S_BR    = 4'd5;
    localparam logic [3:0] S_FIX   = 4'd6;
    localparam logic [3:0] S_STK   = 4'd7;
    localparam logic [3:0] S_RST   = 4'd8;
    localparam logic [3:0] S_BDONE = 4'd9;

    localparam logic [1:0] M_ZPX    = 2'd0;
    localparam logic [1:0] M_ABSX   = 2'd1;
    localparam logic [1:0] M_BRANCH = 2'd2;
    localparam logic [1:0] M_STACK  = 2'd3;

    localparam logic [1:0] D_NONE = 2'b00;
    localparam logic [1:0] D_INC  = 2'b01;
    localparam logic [1:0] D_DEC  = 2'b10;

    localparam logic [2:0] OP_PC   = 3'b000;
    localparam logic [2:0] OP_REG  = 3'b001;
    localparam logic [2:0] OP_BR   = 3'b010;
    localparam logic [2:0] OP_ZPX  = 3'b011;
    localparam logic [2:0] OP_HOLD = 3'b110;
    localparam logic [2:0] OP_ABSX = 3'b111;

    logic [3:0] state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [1:0] dir_q, dir_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= M_ZPX;
            dir_q   <= D_NONE;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
        end
    end

    // Nothing advances on a stalled cycle; co/taken/force_fix only matter when rdy=1.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_d  = mode;
                        state_d = (mode == M_STACK) ? S_STK : S_OPR;
                    end
                end
                S_OPR: begin
                    case (mode_q)
                        M_ZPX:   state_d = S_ZP;
                        M_ABSX:  state_d = S_OPR2;
                        default: state_d = S_BR;
                    endcase
                end
                S_OPR2: state_d = S_AX;
                S_ZP:   state_d = S_RST;
                S_AX: begin
                    if (FIX_EN && (co || force_fix)) begin
                        state_d = S_FIX;
                        dir_d   = co ? D_INC : D_NONE;
                    end else begin
                        state_d = S_RST;
                    end
                end
                S_BR: begin
                    if (taken && FIX_EN && (co ^ db7)) begin
                        state_d = S_FIX;
                        dir_d   = co ? D_INC : D_DEC;
                    end else begin
                        state_d = S_BDONE;
                    end
                end
                S_FIX:   state_d = (mode_q == M_BRANCH) ? S_BDONE : S_RST;
                S_STK:   state_d = S_RST;
                S_RST:   state_d = S_IDLE;
                S_BDONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A stalled cycle drives the idle set regardless of state.
    always_comb begin
        op      = OP_HOLD;
        ci      = 1'b0;
        ld_ahl  = 1'b0;
        ld_pc   = 1'b0;
        inc_pc  = 1'b0;
        abh_zp  = 1'b0;
        abh_stk = 1'b0;
        abh_inc = 1'b0;
        abh_dec = 1'b0;
        done    = 1'b0;
        if (rdy) begin
            case (state_q)
                S_OPR: ci = 1'b1;
                S_OPR2: begin
                    ci     = 1'b1;
                    ld_ahl = 1'b1;
                end
                S_ZP: begin
                    op     = OP_ZPX;
                    abh_zp = 1'b1;
                    ld_pc  = 1'b1;
                    inc_pc = 1'b1;
                end
                S_AX: begin
                    op     = OP_ABSX;
                    ld_pc  = 1'b1;
                    inc_pc = 1'b1;
                end
                S_BR: begin
                    op    = taken ? OP_BR : OP_HOLD;
                    ci    = 1'b1;
                    ld_pc = 1'b1;
                end
                S_FIX: begin
                    abh_inc = (dir_q == D_INC);
                    abh_dec = (dir_q == D_DEC);
                end
                S_STK: begin
                    op      = OP_REG;
                    abh_stk = 1'b1;
                end
                S_RST: begin
                    op   = OP_PC;
                    done = 1'b1;
                end
                S_BDONE: done = 1'b1;
                default: ;
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_abl_seq.sv
// Self-checking bench for abl_seq: per-cycle vector table against a FIX_EN=1 instance,
// plus hand-written sequences comparing FIX_EN=1 and FIX_EN=0 instances side by side.
module tb_abl_seq;

    logic       clk = 1'b0;
    logic       rst_n, start, taken, force_fix, rdy, co, db7;
    logic [1:0] mode;

    logic [2:0] op_a, op_b;
    logic ci_a, ld_ahl_a, ld_pc_a, inc_pc_a, zp_a, stk_a, inc_a, dec_a, busy_a, done_a;
    logic ci_b, ld_ahl_b, ld_pc_b, inc_pc_b, zp_b, stk_b, inc_b, dec_b, busy_b, done_b;

    always #5 clk = ~clk;

    abl_seq #(.FIX_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .taken(taken),
        .force_fix(force_fix), .rdy(rdy), .co(co), .db7(db7),
        .op(op_a), .ci(ci_a), .ld_ahl(ld_ahl_a), .ld_pc(ld_pc_a), .inc_pc(inc_pc_a),
        .abh_zp(zp_a), .abh_stk(stk_a), .abh_inc(inc_a), .abh_dec(dec_a),
        .busy(busy_a), .done(done_a)
    );

    abl_seq #(.FIX_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .taken(taken),
        .force_fix(force_fix), .rdy(rdy), .co(co), .db7(db7),
        .op(op_b), .ci(ci_b), .ld_ahl(ld_ahl_b), .ld_pc(ld_pc_b), .inc_pc(inc_pc_b),
        .abh_zp(zp_b), .abh_stk(stk_b), .abh_inc(inc_b), .abh_dec(dec_b),
        .busy(busy_b), .done(done_b)
    );

    // Output vector layout: {op[2:0], ci, ld_ahl, ld_pc, inc_pc, abh_zp, abh_stk, abh_inc, abh_dec, busy, done}
    logic [12:0] act_a, act_b;
    assign act_a = {op_a, ci_a, ld_ahl_a, ld_pc_a, inc_pc_a, zp_a, stk_a, inc_a, dec_a, busy_a, done_a};
    assign act_b = {op_b, ci_b, ld_ahl_b, ld_pc_b, inc_pc_b, zp_b, stk_b, inc_b, dec_b, busy_b, done_b};

    localparam logic [12:0] E_IDLE  = {3'b110, 10'b0000000000};
    localparam logic [12:0] E_STALL = {3'b110, 10'b0000000010};
    localparam logic [12:0] E_OPR   = {3'b110, 10'b1000000010};
    localparam logic [12:0] E_OPR2  = {3'b110, 10'b1100000010};
    localparam logic [12:0] E_ZP    = {3'b011, 10'b0011100010};
    localparam logic [12:0] E_AX    = {3'b111, 10'b0011000010};
    localparam logic [12:0] E_BRT   = {3'b010, 10'b1010000010};
    localparam logic [12:0] E_BRN   = {3'b110, 10'b1010000010};
    localparam logic [12:0] E_FIXI  = {3'b110, 10'b0000001010};
    localparam logic [12:0] E_FIXD  = {3'b110, 10'b0000000110};
    localparam logic [12:0] E_FIX0  = {3'b110, 10'b0000000010};
    localparam logic [12:0] E_STK   = {3'b001, 10'b0000010010};
    localparam logic [12:0] E_RST   = {3'b000, 10'b0000000011};
    localparam logic [12:0] E_BD    = {3'b110, 10'b0000000011};

    typedef struct {
        logic        rst_n;
        logic        start;
        logic [1:0]  mode;
        logic        taken;
        logic        ff;
        logic        rdy;
        logic        co;
        logic        db7;
        logic [12:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        bit          which;
        logic [12:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic r, input logic s, input logic [1:0] m, input logic t,
                       input logic f, input logic rd, input logic c, input logic d,
                       input logic [12:0] e);
        vec_t v;
        v.rst_n = r; v.start = s; v.mode = m; v.taken = t; v.ff = f;
        v.rdy = rd; v.co = c; v.db7 = d; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic [1:0] m, input logic t,
                         input logic f, input logic rd, input logic c, input logic d);
        rst_n = r; start = s; mode = m; taken = t; force_fix = f; rdy = rd; co = c; db7 = d;
    endtask

    task automatic check_sb();
        sb_t item;
        logic [12:0] act;
        while (sb.size() > 0) begin
            item = sb.pop_front();
            act  = item.which ? act_b : act_a;
            n_chk++;
            if (act !== item.exp) begin
                n_fail++;
                $display("FAIL %s: got %b, expected %b", item.name, act, item.exp);
            end
        end
    endtask

    // One cycle on both instances: drive, queue expectations, sample before the next rising edge.
    task automatic cyc2(input string nm, input logic s, input logic [1:0] m, input logic t,
                        input logic f, input logic c, input logic d,
                        input logic [12:0] ea, input logic [12:0] eb);
        sb_t it;
        @(negedge clk);
        drive(1'b1, s, m, t, f, 1'b1, c, d);
        it.name = {nm, "_fix1"}; it.which = 1'b0; it.exp = ea; sb.push_back(it);
        it.name = {nm, "_fix0"}; it.which = 1'b1; it.exp = eb; sb.push_back(it);
        #1;
        check_sb();
    endtask

    initial begin
        sb_t it;
        // rst, start, mode, taken, ff, rdy, co, db7, expected (dut_a)
        add(1,0,0,0,0,1,0,0, E_IDLE);   // reset state
        add(1,1,1,0,0,1,0,0, E_IDLE);   // ABSX start, then reset mid-sequence
        add(1,0,0,0,0,1,0,0, E_OPR);
        add(0,0,0,0,0,1,0,0, E_OPR2);
        add(0,1,0,0,0,1,0,0, E_IDLE);
        add(1,1,0,0,0,1,0,0, E_IDLE);   // ZPX accepted right after reset release
        add(1,0,0,0,0,1,0,0, E_OPR);
        add(1,0,0,0,0,1,0,0, E_ZP);
        add(1,0,0,0,0,1,0,0, E_RST);
        add(1,0,0,0,0,1,0,0, E_IDLE);
        add(1,1,1,0,0,1,0,0, E_IDLE);   // ABSX, no crossing; start while busy ignored
        add(1,1,1,0,0,1,0,0, E_OPR);
        add(1,0,0,0,0,1,0,0, E_OPR2);
        add(1,0,0,0,0,1,0,0, E_AX);
        add(1,0,0,0,0,1,0,0, E_RST);
        add(1,0,0,0,0,1,0,0, E_IDLE);
        add(1,1,1,0,0,1,0,0, E_IDLE);   // ABSX with crossing
        add(1,0,0,0,0,1,0,0, E_OPR);
        add(1,0,0,0,0,1,0,0, E_OPR2);
        add(1,0,0,0,0,1,1,0, E_AX);
        add(1,0,0,0,0,1,0,0, E_FIXI);
        add(1,0,0,0,0,1,0,0, E_RST);
        add(1,0,0,0,0,1,0,0, E_IDLE);
        add(1,1,1,0,0,1,0,0, E_IDLE);   // ABSX force_fix, no carry
        add(1,0,0,0,0,1,0,0, E_OPR);
        add(1,0,0,0,0,1,0,0, E_OPR2);
        add(1,0,0,0,1,1,0,0, E_AX);
        add(1,0,0,0,0,1,0,0, E_FIX0);
        add(1,0,0,0,0,1,0,0, E_RST);
        add(1,0,0,0,0,1,0,0, E_IDLE);
        add(1,1,2,0,0,1,0,0, E_IDLE);   // branch backward crossing
        add(1,0,0,0,0,1,0,0, E_OPR);
        add(1,0,0,1,0,1,0,1, E_BRT);
        add(1,0,0,0,0,1,0,0, E_FIXD);
        add(1,0,0,0,0,1,0,0, E_BD);
        add(1,0,0,0,0,1,0,0, E_IDLE);
        add(1,1,2,0,0,1,0,0, E_IDLE);   // branch forward crossing
        add(1,0,0,0,0,1,0,0, E_OPR);
        add(1,0,0,1,0,1,1,0, E_BRT);
        add(1,0,0,0,0,1,0,0, E_FIXI);
        add(1,0,0,0,0,1,0,0, E_BD);
        add(1,0,0,0,0,1,0,0, E_IDLE);
        add(1,1,2,0,0,1,0,0, E_IDLE);   // branch taken, co=db7: no fix
        add(1,0,0,0,0,1,0,0, E_OPR);
        add(1,0,0,1,0,1,1,1, E_BRT);
        add(1,0,0,0,0,1,0,0, E_BD);
        add(1,0,0,0,0,1,0,0, E_IDLE);
        add(1,1,2,0,0,1,0,0, E_IDLE);   // branch not taken
        add(1,0,0,0,0,1,0,0, E_OPR);
        add(1,0,0,0,0,1,1,0, E_BRN);
        add(1,0,0,0,0,1,0,0, E_BD);
        add(1,0,0,0,0,1,0,0, E_IDLE);
        add(1,1,3,0,0,1,0,0, E_IDLE);   // stack
        add(1,0,0,0,0,1,0,0, E_STK);
        add(1,0,0,0,0,1,0,0, E_RST);
        add(1,0,0,0,0,1,0,0, E_IDLE);
        add(1,1,1,0,0,1,0,0, E_IDLE);   // ABSX with 3-cycle stall in OPR2
        add(1,0,0,0,0,1,0,0, E_OPR);
        add(1,0,0,0,0,0,0,0, E_STALL);
        add(1,0,0,0,0,0,0,0, E_STALL);
        add(1,0,0,0,0,0,0,0, E_STALL);
        add(1,0,0,0,0,1,0,0, E_OPR2);
        add(1,0,0,0,0,1,0,0, E_AX);
        add(1,0,0,0,0,1,0,0, E_RST);
        add(1,0,0,0,0,1,0,0, E_IDLE);
        add(1,1,0,0,0,0,0,0, E_IDLE);   // start with rdy=0 is not queued
        add(1,0,0,0,0,1,0,0, E_IDLE);
        add(1,0,0,0,0,1,0,0, E_IDLE);
        add(1,1,3,0,0,1,0,0, E_IDLE);   // stall on the done cycle suppresses done
        add(1,0,0,0,0,1,0,0, E_STK);
        add(1,0,0,0,0,0,0,0, E_STALL);
        add(1,0,0,0,0,1,0,0, E_RST);
        add(1,0,0,0,0,1,0,0, E_IDLE);
        add(1,1,1,0,0,1,0,0, E_IDLE);   // co during a stalled AX is ignored
        add(1,0,0,0,0,1,0,0, E_OPR);
        add(1,0,0,0,0,1,0,0, E_OPR2);
        add(1,0,0,0,0,0,1,0, E_STALL);
        add(1,0,0,0,0,1,0,0, E_AX);
        add(1,0,0,0,0,1,0,0, E_RST);
        add(1,0,0,0,0,1,0,0, E_IDLE);

        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst_n, tbl[i].start, tbl[i].mode, tbl[i].taken,
                  tbl[i].ff, tbl[i].rdy, tbl[i].co, tbl[i].db7);
            it.name = $sformatf("row%0d", i); it.which = 1'b0; it.exp = tbl[i].exp;
            sb.push_back(it);
            #1;
            check_sb();
        end

        // Re-align both instances, then compare FIX_EN=1 against FIX_EN=0.
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        cyc2("absx_s",   1, 1, 0, 0, 0, 0, E_IDLE, E_IDLE);
        cyc2("absx_opr", 0, 0, 0, 0, 0, 0, E_OPR,  E_OPR);
        cyc2("absx_op2", 0, 0, 0, 0, 0, 0, E_OPR2, E_OPR2);
        cyc2("absx_ax",  0, 0, 0, 0, 1, 0, E_AX,   E_AX);
        cyc2("absx_c4",  0, 0, 0, 0, 0, 0, E_FIXI, E_RST);
        cyc2("absx_c5",  0, 0, 0, 0, 0, 0, E_RST,  E_IDLE);
        cyc2("absx_c6",  0, 0, 0, 0, 0, 0, E_IDLE, E_IDLE);
        cyc2("ff_s",     1, 1, 0, 0, 0, 0, E_IDLE, E_IDLE);
        cyc2("ff_opr",   0, 0, 0, 0, 0, 0, E_OPR,  E_OPR);
        cyc2("ff_op2",   0, 0, 0, 0, 0, 0, E_OPR2, E_OPR2);
        cyc2("ff_ax",    0, 0, 0, 1, 0, 0, E_AX,   E_AX);
        cyc2("ff_c4",    0, 0, 0, 0, 0, 0, E_FIX0, E_RST);
        cyc2("ff_c5",    0, 0, 0, 0, 0, 0, E_RST,  E_IDLE);
        cyc2("br_s",     1, 2, 0, 0, 0, 0, E_IDLE, E_IDLE);
        cyc2("br_opr",   0, 0, 0, 0, 0, 0, E_OPR,  E_OPR);
        cyc2("br_br",    0, 0, 1, 0, 0, 1, E_BRT,  E_BRT);
        cyc2("br_c3",    0, 0, 0, 0, 0, 0, E_FIXD, E_BD);
        cyc2("br_c4",    0, 0, 0, 0, 0, 0, E_BD,   E_IDLE);
        cyc2("br_c5",    0, 0, 0, 0, 0, 0, E_IDLE, E_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/abl_seq.md
Name: abl_seq

Overview:
- Cycle sequencer for the low address datapath.
- Accepts an addressing-mode request and drives, one state per cycle, the ABL stage-select (op, CI), AHL load, and PCL load/increment controls.
- Drives the high-byte companion strobes: page select, increment and decrement for page-cross fix-ups.
- Sits between the microcode/decode layer and the ABL/ABH datapath; adds RDY stall handling and fix-up cycle insertion.

Parameters:
FIX_EN, 1, 1 = insert FIX cycle on page crossing (indexed absolute, taken branch); 0 = never insert (page wrap)

Ports:
clk  input  1  clock, all state changes on rising edge
rst_n  input  1  synchronous reset, active low
start  input  1  request strobe; sampled only in IDLE with rdy=1
mode  input  2  0=ZPX, 1=ABSX, 2=BRANCH, 3=STACK; sampled with start
taken  input  1  branch condition, sampled in BR state
force_fix  input  1  ABSX: always take FIX cycle (store/RMW)
rdy  input  1  0 = stall current cycle
co  input  1  carry out of ABL adder (combinational, current cycle)
db7  input  1  bit 7 of DB (branch offset sign)
op  output  3  ABL stage select
ci  output  1  ABL adder carry in
ld_ahl  output  1  load AHL from DB
ld_pc  output  1  load PCL from ABL+inc_pc
inc_pc  output  1  PCL increment
abh_zp  output  1  force ABH=00 this cycle
abh_stk  output  1  force ABH=01 this cycle
abh_inc  output  1  ABH += 1
abh_dec  output  1  ABH -= 1
busy  output  1  state != IDLE
done  output  1  one-cycle pulse in final state of a sequence

Behaviour:
- Op codes: PC=000, REG=001, BR=010, ZPX=011, HOLD=110, ABSX=111.
- Idle output set (IDLE, reset, stall): op=110, ci=0; all strobes (ld_ahl, ld_pc, inc_pc, abh_*, done) = 0.
- Reset (rst_n=0 at edge): state=IDLE; outputs take the idle set next cycle, whatever the state or sequence in progress.
- Outputs are combinational from state (and co/db7/taken where noted).
- States and outputs:
  - IDLE: idle set.
  - OPR: op=110, ci=1.
  - OPR2: op=110, ci=1, ld_ahl=1.
  - ZP: op=011, ci=0, abh_zp=1, ld_pc=1, inc_pc=1.
  - AX: op=111, ci=0, ld_pc=1, inc_pc=1.
  - BR, taken=1: op=010, ci=1, ld_pc=1, inc_pc=0.
  - BR, taken=0: op=110, ci=1, ld_pc=1, inc_pc=0.
  - FIX: op=110, ci=0; abh_inc or abh_dec per latched direction.
  - STK: op=001, ci=0, abh_stk=1.
  - RST: op=000, ci=0, done=1.
  - BDONE: op=110, ci=0, done=1.
- Transitions (on edge with rdy=1):
  - IDLE + start: mode0→OPR(ZPX), mode1→OPR(ABSX), mode2→OPR(BR), mode3→STK.
  - ZPX path: OPR→ZP→RST.
  - ABSX path: OPR→OPR2→AX.
  - AX exits to FIX if FIX_EN and (co | force_fix); else RST.
  - FIX always →RST.
  - BR path: OPR→BR.
  - BR, taken=0: →BDONE.
  - BR, taken=1, FIX_EN=1, co^db7=1: →FIX.
    - co=1, db7=0: direction latched = inc.
    - co=0, db7=1: direction latched = dec.
  - BR, taken=1, otherwise: →BDONE.
  - STK→RST.
  - RST and BDONE →IDLE.
- force_fix with co=0 in AX: FIX entered, direction cleared, no abh_inc/abh_dec.
- Branch FIX→RST is not used; branch FIX→BDONE.
- Stall (rdy=0): state, direction and sampled mode held; co/taken/force_fix ignored; idle set driven; done suppressed until the cycle completes with rdy=1.
- start while busy, or while rdy=0: ignored, not queued.
- Latency from start edge to done high, rdy=1 throughout:
  - ZPX: 3 cycles.
  - ABSX: 4 cycles, or 5 with FIX.
  - BRANCH: 3 cycles, or 4 with FIX.
  - STACK: 2 cycles.
- No back-to-back acceptance: minimum one IDLE cycle between sequences.

Test Plan:
- Reset: hold rst_n=0 two cycles mid-ABSX → op=110, ci=0, busy=0, all strobes 0; release, start mode0 accepted next edge.
- ZPX: start mode=0 → op sequence 110/ci1, 011 with abh_zp=1 ld_pc=1 inc_pc=1, 000 with done=1; busy low the following cycle.
- ABSX no cross: mode=1, co=0 in AX, force_fix=0 → 110,110(ld_ahl),111,000; done on cycle 4.
- ABSX cross: co=1 in AX → FIX with abh_inc=1, done on cycle 5.
- ABSX force_fix=1, co=0 → FIX with abh_inc=0 and abh_dec=0.
- Branch backward cross: mode=2, taken=1, db7=1, co=0 → BR op=010 ci=1, FIX abh_dec=1, BDONE done=1.
- Branch not taken: taken=0 → BR op=110 ci=1, then done.
- Stall + FIX_EN=0:
  - rdy=0 for 3 cycles in OPR2 → outputs idle set, ld_ahl=0; sequence resumes with ld_ahl=1, total latency +3.
  - With FIX_EN=0 and co=1 in AX → no FIX cycle.
